// File: rtl/traffic_sensor_conditioner.sv
// Conditions raw lane detectors into debounced presence (S1) and congestion-with-hysteresis (S5).
// Optional stuck-detector supervision is built when SENSOR_FAULT_EN is defined.
module traffic_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned OCC_ON       = 8,
  parameter int unsigned OCC_OFF      = 4,
  parameter int unsigned FAULT_TICKS  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] raw_start,
  input  logic [1:0] raw_cong,
  output logic [1:0] S1,
  output logic [1:0] S5,
  output logic [1:0] fault
);

  localparam int unsigned DebW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned OccMax = (OCC_ON > OCC_OFF) ? OCC_ON : OCC_OFF;
  localparam int unsigned OccW   = $clog2(OccMax + 1);

  localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYC - 1);
  localparam logic [OccW-1:0] OnLast  = OccW'(OCC_ON - 1);
  localparam logic [OccW-1:0] OffLast = OccW'(OCC_OFF - 1);
  localparam logic [OccW-1:0] OccTop  = OccW'(OccMax);

  typedef enum logic {StClear, StCongested} cong_st_e;

  // Bit order everywhere: {cong[1:0], start[1:0]}
  logic [3:0]            sync1_q, sync2_q;
  logic [3:0]            deb_q, deb_d;
  logic [3:0][DebW-1:0]  dcnt_q, dcnt_d;
  logic [1:0]            s1_q;
  logic [1:0]            deb_cong;
  cong_st_e              st_q [2];
  cong_st_e              st_d [2];
  logic [1:0][OccW-1:0]  occ_q, occ_d;
  logic [1:0]            force_clear;

  assign deb_cong = deb_q[3:2];

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DebLast) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef SENSOR_FAULT_EN
  localparam int unsigned FltW = $clog2(FAULT_TICKS + 1);
  localparam logic [FltW-1:0] FltLast = FltW'(FAULT_TICKS - 1);
  localparam logic [FltW-1:0] FltTop  = FltW'(FAULT_TICKS);

  logic [1:0][FltW-1:0] fcnt_q, fcnt_d;
  logic [1:0]           fault_q, fault_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    fault_d = fault_q;
    for (int i = 0; i < 2; i++) begin
      if (!deb_cong[i]) begin
        fcnt_d[i]  = '0;
        fault_d[i] = 1'b0;
      end else if (tick && (fcnt_q[i] != FltTop)) begin
        fcnt_d[i] = fcnt_q[i] + 1'b1;
        if (fcnt_q[i] == FltLast) fault_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      fault_q <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      fault_q <= fault_d;
    end
  end

  assign force_clear = fault_d;
  assign fault       = fault_q;
`else
  assign force_clear = '0;
  assign fault       = '0;
`endif

  always_comb begin
    occ_d = occ_q;
    for (int i = 0; i < 2; i++) begin
      st_d[i] = st_q[i];
      unique case (st_q[i])
        StClear: begin
          if (!deb_cong[i]) begin
            occ_d[i] = '0;
          end else if (tick) begin
            if (occ_q[i] == OnLast) begin
              st_d[i]  = StCongested;
              occ_d[i] = '0;
            end else if (occ_q[i] != OccTop) begin
              occ_d[i] = occ_q[i] + 1'b1;
            end
          end
        end
        StCongested: begin
          if (deb_cong[i]) begin
            occ_d[i] = '0;
          end else if (tick) begin
            if (occ_q[i] == OffLast) begin
              st_d[i]  = StClear;
              occ_d[i] = '0;
            end else if (occ_q[i] != OccTop) begin
              occ_d[i] = occ_q[i] + 1'b1;
            end
          end
        end
        default: ;
      endcase
      // A stuck detector pins the lane in CLEAR until it reads vacant again
      if (force_clear[i]) begin
        st_d[i]  = StClear;
        occ_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      dcnt_q  <= '0;
      s1_q    <= '0;
      occ_q   <= '0;
      for (int i = 0; i < 2; i++) st_q[i] <= StClear;
    end else begin
      sync1_q <= {raw_cong, raw_start};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      s1_q    <= deb_q[1:0];
      occ_q   <= occ_d;
      for (int i = 0; i < 2; i++) st_q[i] <= st_d[i];
    end
  end

  assign S1 = s1_q;
  assign S5 = {st_q[1] == StCongested, st_q[0] == StCongested};

endmodule
